// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes one shared BCD->7-seg decoder across NUM_DIGITS
// common-anode digits. Each digit slot opens with a blanking gap (all anodes off)
// so the decoder input settles before the matching anode switches on.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [3:0]                    dec_bcd,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_done
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0][3:0]     shadow;
  logic [NUM_DIGITS-1:0]          shadow_mask;
  logic                           snap;
  logic [SEL_W-1:0]               sel_nxt, sel_inc;
  logic [NUM_DIGITS-1:0]          an_nxt;
  logic [3:0]                     dec_nxt;
  logic                           fd_nxt;
  logic [NUM_DIGITS-1:0]          lit_vec;
  logic [NUM_DIGITS-1:0]          zero_from;

  // Per-digit visibility: a digit is lit unless masked, not a decimal code,
  // or a suppressed leading zero (every digit from it upward is zero).
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign zero_from[k] = ~|shadow[NUM_DIGITS-1:k];
    assign lit_vec[k]   = !shadow_mask[k] && (shadow[k] <= 4'd9) &&
                          !((LZ_SUPPRESS != 0) && (k > 0) && zero_from[k]);
  end

  assign sel_inc = digit_sel + SEL_W'(1);

  // Next-state and next-output logic; every register is loaded from here.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    sel_nxt   = digit_sel;
    an_nxt    = an_n;
    dec_nxt   = dec_bcd;
    fd_nxt    = 1'b0;
    snap      = 1'b0;
    if (!enable) begin
      // Going dark always wins, including over a frame-end pulse.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sel_nxt   = '0;
      an_nxt    = '1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          sel_nxt   = '0;
          an_nxt    = '1;
          snap      = 1'b1;
          dec_nxt   = digits_in[3:0];
        end
        BLANK: begin
          an_nxt = '1;
          if (cnt == BLANK_LAST) begin
            state_nxt = ON;
            cnt_nxt   = '0;
            an_nxt    = lit_vec[digit_sel] ?
                        ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_sel) : '1;
          end
        end
        ON: begin
          if (cnt == ON_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            an_nxt    = '1;
            if (digit_sel == SEL_LAST) begin
              // Frame wrap: take a fresh snapshot and feed its digit 0 straight
              // to the decoder so it settles during the gap.
              sel_nxt = '0;
              fd_nxt  = 1'b1;
              snap    = 1'b1;
              dec_nxt = digits_in[3:0];
            end else begin
              sel_nxt = sel_inc;
              dec_nxt = shadow[sel_inc];
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sel_nxt   = '0;
          an_nxt    = '1;
        end
      endcase
    end
  end

  // State, counter, shadow snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      shadow_mask <= '0;
      digit_sel   <= '0;
      an_n        <= '1;
      dec_bcd     <= 4'd0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_sel  <= sel_nxt;
      an_n       <= an_nxt;
      dec_bcd    <= dec_nxt;
      frame_done <= fd_nxt;
      if (snap) begin
        shadow      <= digits_in;
        shadow_mask <= blank_mask;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: 4 digits, 8-clock slots, 2-clock blank gap.
// A second instance with leading-zero suppression off runs in lockstep.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_bcd, dec_bcd2;
  logic [3:0]  an_n, an_n2;
  logic [1:0]  digit_sel, digit_sel2;
  logic        frame_done, frame_done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .blank_mask(blank_mask), .dec_bcd(dec_bcd), .an_n(an_n),
    .digit_sel(digit_sel), .frame_done(frame_done)
  );

  display_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(0)
  ) u_dut_nolz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .blank_mask(blank_mask), .dec_bcd(dec_bcd2), .an_n(an_n2),
    .digit_sel(digit_sel2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Never more than one anode low, on either instance.
  always @(negedge clk) begin
    chk("onehot", 32'($countones(~an_n) <= 1), 32'd1);
    chk("onehot2", 32'($countones(~an_n2) <= 1), 32'd1);
  end

  // Called at the negedge showing the first blank cycle of a slot; returns at
  // the first blank cycle of the following slot.
  task automatic slot(input string tag, input logic [1:0] sel, input logic [3:0] dec,
                      input logic [3:0] an_on, input logic [3:0] an_on2, input logic fd_first);
    for (int i = 0; i < 8; i++) begin
      chk({tag, ".an"},  32'(an_n),  32'((i < 2) ? 4'hF : an_on));
      chk({tag, ".an2"}, 32'(an_n2), 32'((i < 2) ? 4'hF : an_on2));
      chk({tag, ".fd"},  32'(frame_done), 32'((i == 0) ? fd_first : 1'b0));
      if (i == 0 || i == 7) begin
        chk({tag, ".dec"}, 32'(dec_bcd), 32'(dec));
        chk({tag, ".sel"}, 32'(digit_sel), 32'(sel));
      end
      @(negedge clk);
    end
  endtask

  // codes/an packed as nibbles, slot k in bits [4k+3:4k].
  task automatic frame(input string tag, input logic [15:0] codes, input logic [15:0] an1,
                       input logic [15:0] an2, input logic fd0);
    for (int k = 0; k < 4; k++)
      slot($sformatf("%s.d%0d", tag, k), 2'(k), codes[4*k +: 4], an1[4*k +: 4],
           an2[4*k +: 4], (k == 0) ? fd0 : 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    digits_in  = 16'h1234;
    blank_mask = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst.an",  32'(an_n), 32'hF);
    chk("rst.dec", 32'(dec_bcd), 32'h0);
    chk("rst.fd",  32'(frame_done), 32'h0);
    chk("rst.sel", 32'(digit_sel), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1234 frames; the next value is queued one frame ahead of when it shows.
    frame("f1", 16'h1234, 16'h7BDE, 16'h7BDE, 1'b0);
    digits_in = 16'h0050;
    frame("f2", 16'h1234, 16'h7BDE, 16'h7BDE, 1'b1);
    digits_in = 16'h0000;
    frame("f3", 16'h0050, 16'hFFDE, 16'h7BDE, 1'b1);
    digits_in = 16'h12A4; blank_mask = 4'b0001;
    frame("f4", 16'h0000, 16'hFFFE, 16'h7BDE, 1'b1);
    digits_in = 16'h1234; blank_mask = 4'b0000;
    frame("f5", 16'h12A4, 16'h7BFF, 16'h7BFF, 1'b1);

    // Mid-frame change stays hidden until the next frame.
    slot("f6.d0", 2'd0, 4'd4, 4'hE, 4'hE, 1'b1);
    digits_in = 16'h5678;
    slot("f6.d1", 2'd1, 4'd3, 4'hD, 4'hD, 1'b0);
    slot("f6.d2", 2'd2, 4'd2, 4'hB, 4'hB, 1'b0);
    slot("f6.d3", 2'd3, 4'd1, 4'h7, 4'h7, 1'b0);
    frame("f7", 16'h5678, 16'h7BDE, 16'h7BDE, 1'b1);

    // Drop enable during an ON cycle of digit 2.
    slot("f8.d0", 2'd0, 4'd8, 4'hE, 4'hE, 1'b1);
    slot("f8.d1", 2'd1, 4'd7, 4'hD, 4'hD, 1'b0);
    repeat (3) @(negedge clk);
    chk("dis.pre.an", 32'(an_n), 32'hB);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dis.an",  32'(an_n), 32'hF);
      chk("dis.sel", 32'(digit_sel), 32'h0);
      chk("dis.fd",  32'(frame_done), 32'h0);
    end

    // Re-enable restarts at digit 0; then drop enable on the final ON cycle.
    enable = 1'b1;
    @(negedge clk);
    slot("re.d0", 2'd0, 4'd8, 4'hE, 4'hE, 1'b0);
    slot("re.d1", 2'd1, 4'd7, 4'hD, 4'hD, 1'b0);
    slot("re.d2", 2'd2, 4'd6, 4'hB, 4'hB, 1'b0);
    repeat (7) @(negedge clk);
    chk("last.an",  32'(an_n), 32'h7);
    chk("last.sel", 32'(digit_sel), 32'h3);
    enable = 1'b0;
    @(negedge clk);
    chk("last.fd",  32'(frame_done), 32'h0);
    chk("last.an2", 32'(an_n), 32'hF);
    chk("last.sel2", 32'(digit_sel), 32'h0);

    // Asynchronous reset in the middle of an ON phase.
    enable = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("arst.pre", 32'(an_n), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.an",  32'(an_n), 32'hF);
    chk("arst.dec", 32'(dec_bcd), 32'h0);
    chk("arst.sel", 32'(digit_sel), 32'h0);
    chk("arst.fd",  32'(frame_done), 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
